fetch_stage: RTL

//  Instruction-fetch stage of the 16-bit pipelined core. Owns the PC, issues word reads to instruction

---
 rtl/cpu_pkg.sv | 26 ++
 rtl/fetch_queue.sv | 56 +++++
 rtl/fetch_stage.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit core: widths, opcodes and fetch FSM states.
// S_HALT is only reachable in builds that define FETCH_HALT_EN.
package cpu_pkg;

  localparam int unsigned PC_W    = 16;
  localparam int unsigned INSTR_W = 16;
  localparam int unsigned OPC_W   = 4;

  localparam logic [OPC_W-1:0] OPC_ALU  = 4'b0000;
  localparam logic [OPC_W-1:0] OPC_LOAD = 4'b0111;
  localparam logic [OPC_W-1:0] OPC_STOR = 4'b1000;
  localparam logic [OPC_W-1:0] OPC_BEQ  = 4'b1100;
  localparam logic [OPC_W-1:0] OPC_JMP  = 4'b1101;
  localparam logic [OPC_W-1:0] OPC_HALT = 4'b1111;

  typedef enum logic [1:0] {
    S_RESET = 2'b00,
    S_FETCH = 2'b01,
    S_HALT  = 2'b10
  } fetch_state_e;

  function automatic logic [OPC_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[INSTR_W-1 -: OPC_W];
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Show-ahead synchronous FIFO holding fetched {instr, pc} entries; clear flushes
// the pointers in one cycle and push+pop may coincide at any occupancy.
module fetch_queue #(
  parameter int unsigned  W     = 32,
  parameter int unsigned  DEPTH = 2,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] rd_ptr_r;
  logic [AW-1:0] wr_ptr_r;
  logic [CW-1:0] count_r;
  logic          do_push_s;
  logic          do_pop_s;

  assign do_pop_s  = pop && (count_r != {CW{1'b0}});
  assign do_push_s = push && ((count_r != CW'(DEPTH)) || do_pop_s);
  assign head      = mem_r[rd_ptr_r];
  assign count     = count_r;

  // pointer, occupancy and storage update
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_r <= {AW{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {W{1'b0}};
      end
    end else if (clear) begin
      rd_ptr_r <= {AW{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r <= count_r + CW'(do_push_s) - CW'(do_pop_s);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, issues credit-limited reads, tags in-order responses
// with their PC and queues them for decode. Define FETCH_HALT_EN to stop fetch on OPC_HALT.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int unsigned     DEPTH    = 2,
  parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [PC_W-1:0]    imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [PC_W-1:0]    if_pc,
  output logic [OPC_W-1:0]   if_opcode
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = CW + 1;
  localparam int unsigned QW = INSTR_W + PC_W;

  fetch_state_e    state_r;
  fetch_state_e    state_nxt_s;
  logic [PC_W-1:0] pc_r;
  logic [CW-1:0]   outstanding_r;
  logic [CW-1:0]   drop_cnt_r;
  logic [CW-1:0]   count_s;
  logic [PC_W-1:0] tag_mem_r [DEPTH];
  logic [AW-1:0]   tag_wr_r;
  logic [AW-1:0]   tag_rd_r;
  logic [QW-1:0]   head_s;
  logic            credit_ok_s;
  logic            issue_s;
  logic            q_valid_s;
  logic            push_s;
  logic            pop_s;

  // Queued words plus in-flight reads never exceed DEPTH, so a push always has room.
  assign credit_ok_s    = ({1'b0, count_s} + {1'b0, outstanding_r}) < SW'(DEPTH);
  assign imem_req_valid = !rst && (state_r == S_FETCH) && !redirect_valid && credit_ok_s;
  assign imem_req_addr  = pc_r;
  assign issue_s        = imem_req_valid && imem_req_ready;

  assign q_valid_s = (count_s != {CW{1'b0}});
  assign pop_s     = q_valid_s && !stall && !redirect_valid;
  assign push_s    = imem_rsp_valid && (drop_cnt_r == {CW{1'b0}}) && !redirect_valid;

  fetch_queue #(
    .W     (QW),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .clear     (redirect_valid),
    .push      (push_s),
    .push_data ({imem_rsp_data, tag_mem_r[tag_rd_r]}),
    .pop       (pop_s),
    .head      (head_s),
    .count     (count_s)
  );

  assign if_valid  = q_valid_s;
  assign if_instr  = q_valid_s ? head_s[QW-1:PC_W] : {INSTR_W{1'b0}};
  assign if_pc     = q_valid_s ? head_s[PC_W-1:0]  : {PC_W{1'b0}};
  assign if_opcode = opcode_of(if_instr);

`ifdef FETCH_HALT_EN
  logic halt_pop_s;
  assign halt_pop_s = pop_s && (opcode_of(head_s[QW-1:PC_W]) == OPC_HALT);
`endif

  // fetch state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_RESET;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_RESET: state_nxt_s = S_FETCH;
      S_FETCH: begin
`ifdef FETCH_HALT_EN
        if (halt_pop_s) state_nxt_s = S_HALT;
        else            state_nxt_s = S_FETCH;
`else
        state_nxt_s = S_FETCH;
`endif
      end
`ifdef FETCH_HALT_EN
      S_HALT: begin
        if (redirect_valid) state_nxt_s = S_FETCH;
        else                state_nxt_s = S_HALT;
      end
`endif
      default: state_nxt_s = S_RESET;
    endcase
  end

  // PC, credit, stale-response and issue-tag bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r          <= RESET_PC;
      outstanding_r <= {CW{1'b0}};
      drop_cnt_r    <= {CW{1'b0}};
      tag_wr_r      <= {AW{1'b0}};
      tag_rd_r      <= {AW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        tag_mem_r[i] <= {PC_W{1'b0}};
      end
    end else begin
      if (redirect_valid) begin
        pc_r <= redirect_pc;
      end else if (issue_s) begin
        pc_r <= pc_r + PC_W'(1);
      end
      outstanding_r <= outstanding_r + CW'(issue_s) - CW'(imem_rsp_valid);
      // Every read still in flight after a redirect belongs to the old path.
      if (redirect_valid) begin
        drop_cnt_r <= outstanding_r - CW'(imem_rsp_valid);
      end else if (imem_rsp_valid && (drop_cnt_r != {CW{1'b0}})) begin
        drop_cnt_r <= drop_cnt_r - CW'(1);
      end
      if (issue_s) begin
        tag_mem_r[tag_wr_r] <= pc_r;
        tag_wr_r            <= tag_wr_r + AW'(1);
      end
      if (imem_rsp_valid) begin
        tag_rd_r <= tag_rd_r + AW'(1);
      end
    end
  end

endmodule
